// File: rtl/sevenseg_value_display.sv
// Clamped binary-to-BCD converter driving N seven-segment digits,
// with leading-zero blanking and a stale-data blink indicator.
module sevenseg_value_display #(
    parameter int VAL_W               = 16,
    parameter int N_DIGITS            = 4,
    parameter int ACTIVE_LOW          = 1,
    parameter int BLANK_LEADING_ZEROS = 1,
    parameter int STALE_CYCLES        = 50_000_000,
    parameter int BLINK_HALF          = 12_500_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [VAL_W-1:0]      in_data,
    output logic                  in_ready,
    output logic [7*N_DIGITS-1:0] hex_out,
    output logic                  overflow,
    output logic                  stale
);

    localparam int BW = 4 * N_DIGITS;
    localparam int CW = $clog2(VAL_W);
    localparam int SW = $clog2(STALE_CYCLES + 1);
    localparam int HW = $clog2(BLINK_HALF + 1);

    function automatic logic [63:0] max_val(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) p = p * 64'd10;
        return p - 64'd1;
    endfunction

    function automatic logic [6:0] seg(input logic [3:0] d);
        logic [6:0] s;
        unique case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    localparam logic [63:0]   MAXV      = max_val(N_DIGITS);
    localparam logic [CW-1:0] LAST      = CW'(VAL_W - 1);
    localparam logic [SW-1:0] STALE_MAX = SW'(STALE_CYCLES);
    localparam logic [HW-1:0] HALF_LAST = HW'(BLINK_HALF - 1);

    typedef enum logic [1:0] {IDLE, CONVERT, LOAD} state_t;

    state_t            state, state_nx;
    logic [VAL_W-1:0]  sh;
    logic [BW-1:0]     bcd, bcd_adj, disp;
    logic [CW-1:0]     cnt;
    logic              ovf_cap;
    logic [SW-1:0]     scnt;
    logic [HW-1:0]     bcnt;
    logic              phase;
    logic              accept, over;
    logic [VAL_W-1:0]  clamped;

    assign accept  = in_valid && in_ready;
    assign over    = 64'(in_data) > MAXV;
    assign clamped = over ? MAXV[VAL_W-1:0] : in_data;
    assign stale   = (scnt == STALE_MAX);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state and handshake
    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = CONVERT;
            end
            CONVERT: if (cnt == LAST) state_nx = LOAD;
            LOAD:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Add 3 to every BCD digit of 5 or more before the next shift
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    // Capture, shift-and-add-3 conversion, and display load
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh       <= '0;
            bcd      <= '0;
            cnt      <= '0;
            ovf_cap  <= 1'b0;
            disp     <= {N_DIGITS{4'hF}};
            overflow <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (accept) begin
                    sh      <= clamped;
                    bcd     <= '0;
                    cnt     <= '0;
                    ovf_cap <= over;
                end
                CONVERT: begin
                    bcd <= {bcd_adj[BW-2:0], sh[VAL_W-1]};
                    sh  <= {sh[VAL_W-2:0], 1'b0};
                    cnt <= cnt + 1'b1;
                end
                LOAD: begin
                    disp     <= bcd;
                    overflow <= ovf_cap;
                end
                default: ;
            endcase
        end
    end

    // Staleness counter and blink phase
    always_ff @(posedge clk) begin
        if (!rst_n || accept) begin
            scnt  <= '0;
            bcnt  <= '0;
            phase <= 1'b0;
        end else begin
            if (scnt != STALE_MAX) scnt <= scnt + 1'b1;
            if (stale) begin
                if (bcnt == HALF_LAST) begin
                    bcnt  <= '0;
                    phase <= ~phase;
                end else begin
                    bcnt <= bcnt + 1'b1;
                end
            end else begin
                bcnt  <= '0;
                phase <= 1'b0;
            end
        end
    end

    // Segment encoding, blanking, then polarity
    always_comb begin
        logic       seen;
        logic       blank;
        logic [3:0] d;
        logic [6:0] pat;
        seen    = 1'b0;
        blank   = 1'b0;
        d       = '0;
        pat     = '0;
        hex_out = '0;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            d     = disp[4*k +: 4];
            blank = (stale && phase) ||
                    (BLANK_LEADING_ZEROS != 0 && k != 0 &&
                     d == 4'd0 && !seen);
            if (d != 4'd0) seen = 1'b1;
            pat = blank ? 7'h00 : seg(d);
            hex_out[7*k +: 7] = (ACTIVE_LOW != 0) ? ~pat : pat;
        end
    end

endmodule

// File: tb/tb_sevenseg_value_display.sv
// Directed checks of sevenseg_value_display: latency, clamping,
// blanking, handshake, stale blink and reset abort.
module tb_sevenseg_value_display;

    localparam logic [27:0] BLANK = {4{7'h7F}};
    localparam logic [27:0] P120  = {7'h7F, 7'h79, 7'h24, 7'h40};
    localparam logic [27:0] P9999 = {4{7'h10}};
    localparam logic [27:0] P7    = {7'h7F, 7'h7F, 7'h7F, 7'h78};
    localparam logic [27:0] P0    = {7'h7F, 7'h7F, 7'h7F, 7'h40};
    localparam logic [27:0] P0NZ  = {4{7'h40}};
    localparam logic [27:0] P1008 = {7'h79, 7'h40, 7'h40, 7'h00};
    localparam logic [27:0] P1    = {7'h7F, 7'h7F, 7'h7F, 7'h79};
    localparam logic [27:0] P2    = {7'h7F, 7'h7F, 7'h7F, 7'h24};
    localparam logic [27:0] P42   = {7'h7F, 7'h7F, 7'h19, 7'h24};
    localparam logic [27:0] P5    = {7'h7F, 7'h7F, 7'h7F, 7'h12};

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready, overflow, stale;
    logic [27:0] hex_out;
    logic        in_ready_nz, overflow_nz, stale_nz;
    logic [27:0] hex_nz;

    int passed = 0;
    int total  = 0;

    sevenseg_value_display #(
        .STALE_CYCLES(100),
        .BLINK_HALF  (10)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_valid(in_valid),
        .in_data (in_data),
        .in_ready(in_ready),
        .hex_out (hex_out),
        .overflow(overflow),
        .stale   (stale)
    );

    sevenseg_value_display #(
        .BLANK_LEADING_ZEROS(0),
        .STALE_CYCLES       (100),
        .BLINK_HALF         (10)
    ) dut_nz (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_valid(in_valid),
        .in_data (in_data),
        .in_ready(in_ready_nz),
        .hex_out (hex_nz),
        .overflow(overflow_nz),
        .stale   (stale_nz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wait_edges(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [15:0] v);
        in_valid = 1'b1;
        in_data  = v;
        wait_edges(1);
        in_valid = 1'b0;
        wait_edges(17);
    endtask

    task automatic test_reset;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        wait_edges(2);
        total++;
        if (hex_out !== BLANK) $display("FAIL reset_hex: got %h want %h", hex_out, BLANK);
        else passed++;
        total++;
        if (overflow !== 1'b0) $display("FAIL reset_ovf: got %b want 0", overflow);
        else passed++;
        total++;
        if (stale !== 1'b0) $display("FAIL reset_stale: got %b want 0", stale);
        else passed++;
        total++;
        if (in_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", in_ready);
        else passed++;
    endtask

    task automatic test_first_after_reset;
        rst_n    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'd120;
        wait_edges(1);
        in_valid = 1'b0;
        total++;
        if (in_ready !== 1'b0) $display("FAIL first_accept: ready %b want 0", in_ready);
        else passed++;
        wait_edges(16);
        total++;
        if (hex_out !== BLANK) $display("FAIL r120_early: got %h want %h", hex_out, BLANK);
        else passed++;
        wait_edges(1);
        total++;
        if (hex_out !== P120) $display("FAIL r120_hex: got %h want %h", hex_out, P120);
        else passed++;
        total++;
        if (overflow !== 1'b0) $display("FAIL r120_ovf: got %b want 0", overflow);
        else passed++;
        total++;
        if (in_ready !== 1'b1) $display("FAIL r120_ready: got %b want 1", in_ready);
        else passed++;
    endtask

    task automatic test_clamp;
        send(16'd12345);
        total++;
        if (hex_out !== P9999) $display("FAIL clamp_hex: got %h want %h", hex_out, P9999);
        else passed++;
        total++;
        if (overflow !== 1'b1) $display("FAIL clamp_ovf: got %b want 1", overflow);
        else passed++;
        send(16'd7);
        total++;
        if (hex_out !== P7) $display("FAIL seven_hex: got %h want %h", hex_out, P7);
        else passed++;
        total++;
        if (overflow !== 1'b0) $display("FAIL seven_ovf: got %b want 0", overflow);
        else passed++;
        send(16'd9999);
        total++;
        if (hex_out !== P9999) $display("FAIL max_hex: got %h want %h", hex_out, P9999);
        else passed++;
        total++;
        if (overflow !== 1'b0) $display("FAIL max_ovf: got %b want 0", overflow);
        else passed++;
        send(16'd1008);
        total++;
        if (hex_out !== P1008) $display("FAIL inner_zero: got %h want %h", hex_out, P1008);
        else passed++;
    endtask

    task automatic test_zero;
        send(16'd0);
        total++;
        if (hex_out !== P0) $display("FAIL zero_hex: got %h want %h", hex_out, P0);
        else passed++;
        total++;
        if (hex_nz !== P0NZ) $display("FAIL zero_noblank: got %h want %h", hex_nz, P0NZ);
        else passed++;
        total++;
        if (overflow_nz !== 1'b0 || in_ready_nz !== 1'b1 || stale_nz !== 1'b0)
            $display("FAIL zero_nz_flags: got %b%b%b want 010",
                     overflow_nz, in_ready_nz, stale_nz);
        else passed++;
    endtask

    task automatic test_back_to_back;
        in_valid = 1'b1;
        in_data  = 16'd1;
        wait_edges(1);
        in_data = 16'd2;
        for (int i = 0; i < 17; i++) begin
            total++;
            if (in_ready !== 1'b0) $display("FAIL b2b_busy%0d: ready %b want 0", i, in_ready);
            else passed++;
            wait_edges(1);
        end
        total++;
        if (in_ready !== 1'b1) $display("FAIL b2b_idle: ready %b want 1", in_ready);
        else passed++;
        total++;
        if (hex_out !== P1) $display("FAIL b2b_first: got %h want %h", hex_out, P1);
        else passed++;
        wait_edges(1);
        in_valid = 1'b0;
        total++;
        if (in_ready !== 1'b0) $display("FAIL b2b_second_acc: ready %b want 0", in_ready);
        else passed++;
        wait_edges(16);
        total++;
        if (hex_out !== P1) $display("FAIL b2b_hold: got %h want %h", hex_out, P1);
        else passed++;
        wait_edges(1);
        total++;
        if (hex_out !== P2) $display("FAIL b2b_second: got %h want %h", hex_out, P2);
        else passed++;
    endtask

    task automatic test_stale;
        in_valid = 1'b1;
        in_data  = 16'd42;
        wait_edges(1);
        in_valid = 1'b0;
        wait_edges(99);
        total++;
        if (stale !== 1'b0 || hex_out !== P42)
            $display("FAIL stale_pre: stale %b hex %h want 0 %h", stale, hex_out, P42);
        else passed++;
        wait_edges(1);
        total++;
        if (stale !== 1'b1 || hex_out !== P42)
            $display("FAIL stale_rise: stale %b hex %h want 1 %h", stale, hex_out, P42);
        else passed++;
        wait_edges(9);
        total++;
        if (hex_out !== P42) $display("FAIL blink_on_end: got %h want %h", hex_out, P42);
        else passed++;
        wait_edges(1);
        total++;
        if (hex_out !== BLANK) $display("FAIL blink_off: got %h want %h", hex_out, BLANK);
        else passed++;
        total++;
        if (overflow !== 1'b0) $display("FAIL blink_ovf: got %b want 0", overflow);
        else passed++;
        wait_edges(9);
        total++;
        if (hex_out !== BLANK) $display("FAIL blink_off_end: got %h want %h", hex_out, BLANK);
        else passed++;
        wait_edges(1);
        total++;
        if (hex_out !== P42) $display("FAIL blink_on2: got %h want %h", hex_out, P42);
        else passed++;
        wait_edges(10);
        total++;
        if (hex_out !== BLANK) $display("FAIL blink_off2: got %h want %h", hex_out, BLANK);
        else passed++;
        in_valid = 1'b1;
        in_data  = 16'd5;
        wait_edges(1);
        in_valid = 1'b0;
        total++;
        if (stale !== 1'b0) $display("FAIL stale_clear: got %b want 0", stale);
        else passed++;
        total++;
        if (hex_out !== P42) $display("FAIL stale_steady: got %h want %h", hex_out, P42);
        else passed++;
        wait_edges(17);
        total++;
        if (hex_out !== P5 || stale !== 1'b0)
            $display("FAIL stale_new: hex %h stale %b want %h 0", hex_out, stale, P5);
        else passed++;
    endtask

    task automatic test_reset_abort;
        send(16'd10000);
        total++;
        if (overflow !== 1'b1 || hex_out !== P9999)
            $display("FAIL pre_abort: ovf %b hex %h want 1 %h", overflow, hex_out, P9999);
        else passed++;
        in_valid = 1'b1;
        in_data  = 16'd4321;
        wait_edges(1);
        in_valid = 1'b0;
        wait_edges(7);
        rst_n = 1'b0;
        wait_edges(1);
        total++;
        if (hex_out !== BLANK) $display("FAIL abort_hex: got %h want %h", hex_out, BLANK);
        else passed++;
        total++;
        if (overflow !== 1'b0) $display("FAIL abort_ovf: got %b want 0", overflow);
        else passed++;
        total++;
        if (in_ready !== 1'b1) $display("FAIL abort_ready: got %b want 1", in_ready);
        else passed++;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            wait_edges(1);
            total++;
            if (hex_out !== BLANK) $display("FAIL abort_hold%0d: got %h want %h", i, hex_out, BLANK);
            else passed++;
        end
    endtask

    initial begin
        test_reset;
        test_first_after_reset;
        test_clamp;
        test_zero;
        test_back_to_back;
        test_stale;
        test_reset_abort;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sevenseg_value_display.md
SEVENSEG_VALUE_DISPLAY -- requirements
Module: sevenseg_value_display

Interface
REQ-001 SHALL provide parameter VAL_W, default 16, width of the unsigned input value (4..32).
REQ-002 SHALL provide parameter N_DIGITS, default 4, number of decimal digits driven (1..8).
REQ-003 SHALL provide parameter ACTIVE_LOW, default 1; 1 = segment lit by 0, 0 = segment lit by 1.
REQ-004 SHALL provide parameter BLANK_LEADING_ZEROS, default 1, enabling leading-zero suppression.
REQ-005 SHALL provide parameter STALE_CYCLES, default 50_000_000, clocks without a new sample before stale.
REQ-006 SHALL provide parameter BLINK_HALF, default 12_500_000, clocks per blink half-period while stale.
REQ-007 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-008 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-009 SHALL have port in_valid  input  1  sample offered.
REQ-010 SHALL have port in_data  input  VAL_W  unsigned sample value.
REQ-011 SHALL have port in_ready  output  1  block can accept a sample this cycle.
REQ-012 SHALL have port hex_out  output  7*N_DIGITS  segments; digit k (k=0 ones) at bits [7k+6:7k], bit order g..a.
REQ-013 SHALL have port overflow  output  1  last displayed sample was clamped.
REQ-014 SHALL have port stale  output  1  no sample accepted for STALE_CYCLES clocks.

Function
REQ-015 SHALL use FSM states IDLE, CONVERT, LOAD; IDLE->CONVERT on in_valid&&in_ready; CONVERT->LOAD after exactly VAL_W cycles; LOAD->IDLE unconditionally.
REQ-016 SHALL drive in_ready=1 only in IDLE; in_valid in CONVERT/LOAD is ignored and not queued.
REQ-017 SHALL compute MAXV = 10^N_DIGITS-1 at elaboration; an accepted sample > MAXV is replaced by MAXV and its overflow flag captured as 1, else 0.
REQ-018 SHALL convert binary to BCD sequentially (shift-and-add-3, one bit per cycle, MSB first) into a 4*N_DIGITS register; no divide/modulo operators.
REQ-019 SHALL, in LOAD, update displayed digits and overflow together; sample accepted on edge t is visible on hex_out after edge t+VAL_W+1.
REQ-020 SHALL hold hex_out and overflow constant between LOAD cycles.
REQ-021 SHALL encode digits 0-9 with standard patterns (0=a..f, 1=b,c, 7=a,b,c, 8=all, 9=a,b,c,d,f,g); codes 10-15 blank.
REQ-022 SHALL, when BLANK_LEADING_ZEROS=1, blank every zero digit above the highest nonzero digit; digit 0 is never blanked.
REQ-023 SHALL apply polarity last: blank = all segments off in the selected polarity.
REQ-024 SHALL count clocks since last acceptance, saturating at STALE_CYCLES; stale=1 while count==STALE_CYCLES; acceptance clears count and stale on the next edge.
REQ-025 SHALL, while stale=1, toggle a blink phase every BLINK_HALF clocks starting in the "on" phase; during "off" all digits are blank; on stale clear the display is immediately steady-on.
REQ-026 SHALL keep overflow value unaffected by blinking.

Reset
REQ-027 SHALL, on rst_n=0 at a clock edge: state=IDLE, in_ready=1, hex_out all blank, overflow=0, stale=0, stale counter, blink counter and phase 0.
REQ-028 SHALL abort any conversion in progress when reset is applied; no partial result is loaded.
REQ-029 SHALL accept a sample on the first edge after rst_n returns high.

Verification (VAL_W=16, N_DIGITS=4, ACTIVE_LOW=1, STALE_CYCLES=100, BLINK_HALF=10)
REQ-030 SHALL cover: in_data=120 accepted at edge t -> at t+17 hex_out = {7'h7F, 7'h79, 7'h24, 7'h40}, overflow=0, in_ready=1.
REQ-031 SHALL cover: in_data=12345 -> display 9999 (four 7'h10), overflow=1; next sample 7 -> {7'h7F,7'h7F,7'h7F,7'h78}, overflow=0.
REQ-032 SHALL cover: in_data=0 -> three blanks plus 7'h40; with BLANK_LEADING_ZEROS=0 -> four 7'h40.
REQ-033 SHALL cover: in_valid held high with values 1,2 during CONVERT -> in_ready=0 for 17 cycles, only first value displayed, second accepted only when IDLE.
REQ-034 SHALL cover: no sample for 100 clocks -> stale=1, digits alternate displayed/blank every 10 clocks; new sample -> stale=0 next edge, steady display after load.
REQ-035 SHALL cover: rst_n=0 at cycle 8 of a conversion of 4321 -> all blank, overflow=0, in_ready=1; 4321 never appears.
